// File: rtl/microwave_controller.sv
// microwave_controller
//   Top-level sequencer of the microwave oven. Takes the keypad encoder
//   outputs (BCD digit, active-low valid strobe, 1 Hz pulse) plus the
//   start/stop buttons and the door switch. Runs an IDLE/ENTRY/COOK/PAUSE/DONE
//   state machine, holds the MM:SS cook time as four BCD digits, counts it
//   down once per second and drives the magnetron enable.
//
//   Optional feature macro: BUZZER_EN
//     defined   : beep = registered (done & pgt_1hz), plus a one-clock beep
//                 on every accepted keypress.
//     undefined : beep tied low, no buzzer logic.
//
//   Handshake/event semantics: there is no valid/ready traffic here. Every
//   control input is a level that is registered once; an event is the
//   registered copy differing from the live value in the active direction
//   (falling for loadn/startn/stopn, rising for pgt_1hz). The event is acted
//   on at the same clk edge at which it is detected.
//
//   state_dbg exposes the FSM state for checkers:
//     0 = IDLE, 1 = ENTRY, 2 = COOK, 3 = PAUSE, 4 = DONE.

module microwave_controller #(
  parameter int unsigned DONE_SECONDS = 3
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] bcd_digit,
  input  logic       loadn,
  input  logic       pgt_1hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       mag_on,
  output logic       done,
  output logic       beep,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Tick count at which DONE gives way to IDLE (counter starts at 0).
  localparam logic [3:0] DONE_LAST = 4'(DONE_SECONDS - 1);

  state_t     state_q, state_d;
  logic [3:0] min_tens_q, min_units_q, sec_tens_q, sec_units_q;
  logic [3:0] min_tens_d, min_units_d, sec_tens_d, sec_units_d;
  logic [3:0] done_cnt_q, done_cnt_d;
  logic       mag_on_q, done_q;

  // Edge-detect history.
  logic       loadn_q, startn_q, stopn_q, pgt_q;

  // Decoded events for this clk.
  logic       key_ev, start_ev, stop_ev, tick_ev;
  logic       time_zero;
  logic       start_go;
  logic       key_take;

  // Decremented time (BCD with borrow) and helpers.
  logic [3:0] dec_min_tens, dec_min_units, dec_sec_tens, dec_sec_units;
  logic       borrow_su, borrow_st, borrow_mu;
  logic       dec_zero;

  assign key_ev   = loadn_q  & ~loadn;
  assign start_ev = startn_q & ~startn;
  assign stop_ev  = stopn_q  & ~stopn;
  assign tick_ev  = ~pgt_q   & pgt_1hz;

  assign time_zero = (min_tens_q == 4'd0) && (min_units_q == 4'd0) &&
                     (sec_tens_q == 4'd0) && (sec_units_q == 4'd0);

  // A start that actually launches cooking from IDLE/ENTRY.
  assign start_go = start_ev & door_closed & ~time_zero;

  // A keypress that is entered when the FSM is in IDLE/ENTRY: stop and a
  // successful start both outrank it, and non-decimal codes are dropped.
  assign key_take = key_ev & (bcd_digit <= 4'd9) & ~stop_ev & ~start_go;

  // One-second BCD decrement of MM:SS; sec_tens may legally hold 6..9.
  always_comb begin
    borrow_su     = (sec_units_q == 4'd0);
    dec_sec_units = borrow_su ? 4'd9 : sec_units_q - 4'd1;

    borrow_st     = borrow_su && (sec_tens_q == 4'd0);
    dec_sec_tens  = sec_tens_q;
    if (borrow_su) begin
      dec_sec_tens = (sec_tens_q == 4'd0) ? 4'd5 : sec_tens_q - 4'd1;
    end

    borrow_mu     = borrow_st && (min_units_q == 4'd0);
    dec_min_units = min_units_q;
    if (borrow_st) begin
      dec_min_units = (min_units_q == 4'd0) ? 4'd9 : min_units_q - 4'd1;
    end

    // Never wraps: COOK is only entered with a non-zero time.
    dec_min_tens  = min_tens_q;
    if (borrow_mu && (min_tens_q != 4'd0)) begin
      dec_min_tens = min_tens_q - 4'd1;
    end

    dec_zero = (dec_min_tens == 4'd0) && (dec_min_units == 4'd0) &&
               (dec_sec_tens == 4'd0) && (dec_sec_units == 4'd0);
  end

  // Next-state and next-time selection, in priority stop > door > start > tick > key.
  always_comb begin
    state_d     = state_q;
    min_tens_d  = min_tens_q;
    min_units_d = min_units_q;
    sec_tens_d  = sec_tens_q;
    sec_units_d = sec_units_q;
    done_cnt_d  = done_cnt_q;

    unique case (state_q)
      S_IDLE, S_ENTRY: begin
        if (stop_ev) begin
          state_d     = S_IDLE;
          min_tens_d  = 4'd0;
          min_units_d = 4'd0;
          sec_tens_d  = 4'd0;
          sec_units_d = 4'd0;
        end else if (start_go) begin
          state_d = S_COOK;
        end else if (key_take) begin
          // The first key in IDLE starts a fresh entry from 00:00.
          state_d     = S_ENTRY;
          min_tens_d  = (state_q == S_IDLE) ? 4'd0 : min_units_q;
          min_units_d = (state_q == S_IDLE) ? 4'd0 : sec_tens_q;
          sec_tens_d  = (state_q == S_IDLE) ? 4'd0 : sec_units_q;
          sec_units_d = bcd_digit;
        end
      end

      S_COOK: begin
        if (stop_ev || !door_closed) begin
          // Time is held so cooking can resume from PAUSE.
          state_d = S_PAUSE;
        end else if (tick_ev) begin
          min_tens_d  = dec_min_tens;
          min_units_d = dec_min_units;
          sec_tens_d  = dec_sec_tens;
          sec_units_d = dec_sec_units;
          if (dec_zero) begin
            state_d    = S_DONE;
            done_cnt_d = 4'd0;
          end
        end
      end

      S_PAUSE: begin
        if (stop_ev) begin
          state_d     = S_IDLE;
          min_tens_d  = 4'd0;
          min_units_d = 4'd0;
          sec_tens_d  = 4'd0;
          sec_units_d = 4'd0;
        end else if (start_ev && door_closed) begin
          state_d = S_COOK;
        end
      end

      S_DONE: begin
        // Time already reads 00:00 here; any exit lands in IDLE.
        if (stop_ev) begin
          state_d = S_IDLE;
        end else if (tick_ev) begin
          if (done_cnt_q == DONE_LAST) begin
            state_d = S_IDLE;
          end else begin
            done_cnt_d = done_cnt_q + 4'd1;
          end
        end else if (key_ev) begin
          // The key only dismisses DONE; it is not entered.
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        min_tens_d  = 4'd0;
        min_units_d = 4'd0;
        sec_tens_d  = 4'd0;
        sec_units_d = 4'd0;
      end
    endcase
  end

  // State, time digits, registered outputs and edge-detect history.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= S_IDLE;
      min_tens_q  <= 4'd0;
      min_units_q <= 4'd0;
      sec_tens_q  <= 4'd0;
      sec_units_q <= 4'd0;
      done_cnt_q  <= 4'd0;
      mag_on_q    <= 1'b0;
      done_q      <= 1'b0;
      loadn_q     <= 1'b1;
      startn_q    <= 1'b1;
      stopn_q     <= 1'b1;
      pgt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_tens_q  <= min_tens_d;
      min_units_q <= min_units_d;
      sec_tens_q  <= sec_tens_d;
      sec_units_q <= sec_units_d;
      done_cnt_q  <= done_cnt_d;
      mag_on_q    <= (state_d == S_COOK);
      done_q      <= (state_d == S_DONE);
      loadn_q     <= loadn;
      startn_q    <= startn;
      stopn_q     <= stopn;
      pgt_q       <= pgt_1hz;
    end
  end

`ifdef BUZZER_EN
  logic beep_q;
  logic in_entry_states;

  assign in_entry_states = (state_q == S_IDLE) || (state_q == S_ENTRY);

  // Buzzer: follows the 1 Hz pulse while done, plus a click per accepted key.
  always_ff @(posedge clk) begin
    if (clear) begin
      beep_q <= 1'b0;
    end else begin
      beep_q <= (done_q & pgt_1hz) | (key_take & in_entry_states);
    end
  end

  assign beep = beep_q;
`else
  assign beep = 1'b0;
`endif

  assign min_tens  = min_tens_q;
  assign min_units = min_units_q;
  assign sec_tens  = sec_tens_q;
  assign sec_units = sec_units_q;
  assign mag_on    = mag_on_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule
